enc8to3_serializer: RTL and testbench
=====================================

Name: enc8to3_serializer

Overview:
- Sequential 8-to-3 encoder; the reverse direction of the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit request vector Y, in which any number of bits may be set.
- Emits the 3-bit index A of each set bit, one per accepted output handshake, highest index first.
- Sits between decoded request lines and consumers that need binary indices, for example an arbiter-to-address path.

Parameters:
- N, 8, input vector width. The implementation supports only N=8; it must be a power of two.
- W, 3, index width; W = log2(N).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Y  input  N  request vector; sampled when load_valid & load_ready.
- load_valid  input  1  Y is valid.
- load_ready  output  1  block can accept Y.
- A  output  W  encoded index of the current highest pending bit.
- out_valid  output  1  A is valid.
- out_ready  input  1  consumer takes A.
- remaining  output  W+1  popcount of the pending register (0..8).
- none  output  1  one-cycle pulse: an all-zero Y was accepted.
- done  output  1  one-cycle pulse: the last pending index was consumed.

Behaviour:
- State is a pending[N-1:0] register plus a 2-state FSM: IDLE, BUSY.
- Reset (rst=1 at a rising edge, in any state):
  - pending=0, FSM=IDLE.
  - out_valid=0, A=0, remaining=0, none=0, done=0, load_ready=1 after that edge.
  - Reset mid-drain discards every pending bit; no done pulse is issued.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid with Y!=0: pending<=Y, go BUSY.
  - On load_valid with Y==0: none=1 for the next cycle only, stay IDLE.
- BUSY:
  - out_valid=1.
  - A = index of the highest set bit of pending, derived only from registers, so it is stable while out_valid=1.
  - Without the optional feature, load_ready=0 and load_valid is ignored.
- Output handshake: a transfer occurs when out_valid & out_ready at a rising edge.
  - On a transfer, pending bit A clears.
  - If the cleared pending becomes 0: go IDLE, done=1 for the next cycle, out_valid=0 from that cycle.
  - If out_ready=0, A and out_valid must hold unchanged for any number of cycles.
- Latency:
  - Y accepted at edge t gives out_valid=1 and A valid in cycle t+1.
  - Back-to-back transfers with out_ready held high produce one index per cycle.
  - A k-bit vector drains in k cycles; the next load is accepted the cycle done is high.
- remaining:
  - Equals popcount(pending) after every edge.
  - Decrements by 1 per transfer.
  - 0 in IDLE.
- Example: Y=8'b1010_0100 gives A = 7, then 5, then 2.
- A is never driven to a value whose pending bit is clear while out_valid=1.

Optional Feature:
- Macro: ENC_MERGE_EN.
- Defined:
  - load_ready=1 in both states.
  - In BUSY, an accepted Y is OR-merged: pending <= (pending & ~served) | Y, where served is the one-hot of A if a transfer happens the same edge, else 0.
  - A Y bit equal to the bit served in the same cycle stays set and is re-emitted.
  - An accepted Y==0 in BUSY still pulses none and leaves pending unchanged apart from the served bit.
  - done fires only when the merged result is 0.
  - A may change after an edge at which out_valid & out_ready was not asserted only by moving to a higher index introduced by a merge.
- Undefined: behaviour exactly as described above; load_ready=0 in BUSY.

Test Plan:
- Single bits: each of Y=8'h01, 8'h02, ... 8'h80 loaded with out_ready=1 -> one transfer with A = 0..7 respectively, remaining 1->0, done pulses once, FSM back to IDLE.
- Full vector: Y=8'hFF, out_ready=1 -> A = 7,6,5,4,3,2,1,0 on 8 consecutive cycles, remaining 8->0, load_ready=0 throughout (macro undefined).
- Backpressure: Y=8'h24, out_ready low for 5 cycles then high -> A=5 and out_valid=1 held stable for 5 cycles, then A=2, then done.
- Zero input: Y=8'h00 with load_valid=1 -> none=1 for exactly one cycle, out_valid stays 0, FSM stays IDLE.
- Reset mid-drain: Y=8'hF0, rst asserted after 2 transfers -> next cycle out_valid=0, remaining=0, no done pulse; a following Y=8'h01 yields A=0.
- ENC_MERGE_EN defined: Y=8'h11 draining; in the cycle A=4 is transferred, load Y=8'h90 -> following outputs A=7, 4, 0 (merge keeps bit 4), done after the third transfer.

Source files
------------

// File: rtl/enc8to3_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : enc8to3_serializer
//  Description : Sequential 8-to-3 encoder. Emits the index of every set bit
//                of an accepted request vector, highest first, one per output
//                handshake. Optional OR-merge of new requests while draining
//                is enabled by defining ENC_MERGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc8to3_serializer #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] Y,
    input  logic         load_valid,
    output logic         load_ready,
    output logic [W-1:0] A,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   remaining,
    output logic         none,
    output logic         done
);

    localparam int         c_CNT_W   = W + 1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    if (N != 8 || W != 3) begin : g_param_check
        $error("enc8to3_serializer supports only N=8, W=3");
    end

    logic [0:0]       r_state;
    logic [N-1:0]     r_pending;
    logic [W-1:0]     r_a;
    logic             r_out_valid;
    logic [c_CNT_W-1:0] r_remaining;
    logic             r_none;
    logic             r_done;
    logic             r_load_ready;

    logic             w_xfer;
    logic             w_load;
    logic [N-1:0]     w_served;
    logic [N-1:0]     w_pending_next;
    logic             w_pending_empty;
    logic [W-1:0]     w_a_next;
    logic [c_CNT_W-1:0] w_count_next;

    assign w_xfer   = r_out_valid & out_ready;
    assign w_load   = load_valid & r_load_ready;
    assign w_served = w_xfer ? (N'(1) << r_a) : '0;

    // Without merging, load_ready is low in BUSY, so the OR term only
    // contributes when pending is already empty.
    assign w_pending_next  = (r_pending & ~w_served) | (w_load ? Y : '0);
    assign w_pending_empty = (w_pending_next == '0);

    // Next outputs are computed from the next pending value so A and
    // remaining leave the flops already consistent with r_pending.
    always_comb begin
        w_a_next     = '0;
        w_count_next = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pending_next[i]) begin
                w_a_next = W'(i);
            end
            w_count_next = w_count_next + c_CNT_W'(w_pending_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_pending    <= '0;
            r_a          <= '0;
            r_out_valid  <= 1'b0;
            r_remaining  <= '0;
            r_none       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_pending   <= w_pending_next;
            r_a         <= w_a_next;
            r_remaining <= w_count_next;
            r_none      <= w_load & (Y == '0);
            r_out_valid <= ~w_pending_empty;
`ifdef ENC_MERGE_EN
            r_load_ready <= 1'b1;
`else
            r_load_ready <= w_pending_empty;
`endif
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (!w_pending_empty) begin
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    r_done <= w_xfer & w_pending_empty;
                    if (w_pending_empty) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready = r_load_ready;
    assign A          = r_a;
    assign out_valid  = r_out_valid;
    assign remaining  = r_remaining;
    assign none       = r_none;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_enc8to3_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc8to3_serializer
//  Description : Self-checking bench for enc8to3_serializer: directed
//                scenarios plus randomized traffic against a behavioural model.
//                Merge scenarios are compiled in when ENC_MERGE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc8to3_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Y;
    logic       load_valid;
    logic       load_ready;
    logic [2:0] A;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] remaining;
    logic       none;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the set of indices still owed to the consumer
    // plus the two single-cycle event flags.
    logic [7:0] m_pending;
    logic       m_none;
    logic       m_done;

    always #5 clk = ~clk;

    enc8to3_serializer #(.N(8), .W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .Y          (Y),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .A          (A),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .remaining  (remaining),
        .none       (none),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int highest_index(input logic [7:0] v);
        int r = 0;
        int x = int'(v);
        while (x > 1) begin
            x = x / 2;
            r++;
        end
        return r;
    endfunction

    function automatic logic model_load_ready();
`ifdef ENC_MERGE_EN
        return 1'b1;
`else
        return (m_pending == 8'h00);
`endif
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", out_valid, m_pending != 8'h00);
        check_eq("load_ready", load_ready, model_load_ready());
        check_eq("remaining", remaining, $countones(m_pending));
        check_eq("none", none, m_none);
        check_eq("done", done, m_done);
        if (m_pending != 8'h00) begin
            check_eq("A", A, highest_index(m_pending));
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, then
    // compare on the falling edge.
    task automatic step(input logic r, input logic lv, input logic [7:0] y, input logic ordy);
        logic       xfer;
        logic       ld;
        logic [7:0] served;
        logic [7:0] next_p;
        rst        = r;
        load_valid = lv;
        Y          = y;
        out_ready  = ordy;
        @(posedge clk);
        if (r) begin
            m_pending = 8'h00;
            m_none    = 1'b0;
            m_done    = 1'b0;
        end else begin
            xfer   = (m_pending != 8'h00) && ordy;
            ld     = lv && model_load_ready();
            served = xfer ? (8'h01 << highest_index(m_pending)) : 8'h00;
            next_p = (m_pending & ~served) | (ld ? y : 8'h00);
            m_none = ld && (y == 8'h00);
            m_done = xfer && (next_p == 8'h00);
            m_pending = next_p;
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst        = 1'b1;
        Y          = 8'h00;
        load_valid = 1'b0;
        out_ready  = 1'b0;
        m_pending  = 8'h00;
        m_none     = 1'b0;
        m_done     = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("reset_A", A, 0);

        // Single bits: one transfer each, A equals the bit position.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h01 << i, 1'b1);
            check_eq("single_A", A, i);
            step(1'b0, 1'b0, 8'h00, 1'b1);
            check_eq("single_done", done, 1);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Full vector drains highest first, one index per cycle.
        step(1'b0, 1'b1, 8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            check_eq("full_A", A, 7 - k);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_eq("full_done", done, 1);

        // Documented example.
        step(1'b0, 1'b1, 8'hA4, 1'b1);
        check_eq("ex_A7", A, 7);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("ex_A5", A, 5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("ex_A2", A, 2);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure holds A and out_valid.
        step(1'b0, 1'b1, 8'h24, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_hold_A", A, 5);
            step(1'b0, 1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("bp_A2", A, 2);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("bp_done", done, 1);

        // Zero input pulses none for exactly one cycle.
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check_eq("zero_none", none, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("zero_none_clear", none, 0);

        // Reset mid-drain discards pending bits without a done pulse.
        step(1'b0, 1'b1, 8'hF0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_remaining", remaining, 0);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        check_eq("after_rst_A", A, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

`ifdef ENC_MERGE_EN
        // Merge while the served bit is reloaded: 4 is re-emitted.
        step(1'b0, 1'b1, 8'h11, 1'b1);
        check_eq("merge_A4", A, 4);
        step(1'b0, 1'b1, 8'h90, 1'b1);
        check_eq("merge_A7", A, 7);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("merge_A4b", A, 4);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("merge_A0", A, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check_eq("merge_done", done, 1);
`endif

        // Randomized traffic with occasional zero vectors and resets.
        for (int n = 0; n < 2000; n++) begin
            logic [7:0] ry;
            ry = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            step(($urandom_range(0, 99) == 0), 1'($urandom), ry, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
